// File: rtl/sec32_pkg.sv
// Shared definitions for the 32-bit single-error-correcting code: masks, widths
// and the codeword layout used by both the check encoder and the corrector.
package sec32_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;

  // Row k selects the data bits covered by check bit c[k] (even parity).
  localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
  } codeword_t;

endpackage

// File: rtl/sec32_parity_gen.sv
// Combinational check-bit generator: each check bit is the even parity of the
// data bits selected by its CHK_MASK row.
module sec32_parity_gen
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CHK_W-1:0]  check_o
);

  always_comb begin
    check_o = '0;
    for (int k = 0; k < CHK_W; k++) begin
      check_o[k] = ^(data_i & CHK_MASK[k]);
    end
  end

endmodule

// File: rtl/sec32_check_encoder.sv
// SEC check encoder on a valid/ready stream: computes check bits, optionally
// injects faults, and buffers codewords in a main + skid elastic pair.
module sec32_check_encoder
  import sec32_pkg::*;
#(
  parameter int INJ_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W+CHK_W-1:0]  in_inj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHK_W-1:0]         out_check,
  output logic                     out_en,
  output logic [CNT_W-1:0]         words_out
);

  logic [CHK_W-1:0]          raw_check;
  logic [DATA_W+CHK_W-1:0]   inj_eff;
  codeword_t                 new_word;

  codeword_t                 main_q, main_d;
  codeword_t                 skid_q, skid_d;
  logic                      main_vld_q, main_vld_d;
  logic                      skid_vld_q, skid_vld_d;
  logic                      in_ready_q, in_ready_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      accept;
  logic                      out_hs;

  sec32_parity_gen u_parity (
    .data_i  (in_data),
    .check_o (raw_check)
  );

  // Check bits always come from the clean data; the mask only corrupts storage.
  assign inj_eff        = (INJ_EN != 0) ? in_inj : '0;
  assign new_word.data  = in_data ^ inj_eff[DATA_W-1:0];
  assign new_word.check = raw_check ^ inj_eff[DATA_W+CHK_W-1:DATA_W];

  assign accept = in_valid & in_ready_q;
  assign out_hs = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (main_vld_q && !out_ready) begin
      // Main is stalled: a new word can only land in the skid slot.
      if (accept) begin
        skid_d     = new_word;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      // in_ready is low whenever skid is full, so no accept can collide here.
      main_d     = skid_q;
      main_vld_d = 1'b1;
      skid_vld_d = 1'b0;
    end else begin
      main_vld_d = accept;
      if (accept) begin
        main_d = new_word;
      end
    end
    in_ready_d = ~skid_vld_d;
    cnt_d      = cnt_q + CNT_W'(out_hs);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_en    = main_vld_q;
  assign out_data  = main_q.data;
  assign out_check = main_q.check;
  assign words_out = cnt_q;

endmodule

// File: tb/tb_sec32_check_encoder.sv
// Directed bench for sec32_check_encoder: three instances share one stimulus
// stream (plain, fault-injecting, and 4-bit counter) and a common scoreboard.
module tb_sec32_check_encoder;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // inputs are driven 1 time unit after posedge, outputs sampled there or at negedge.

  localparam logic [31:0] TB_MASK [0:7] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [39:0] in_inj;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_en0;
  logic [31:0] out_data0;
  logic [7:0]  out_check0;
  logic [15:0] words_out0;

  logic        in_ready1, out_valid1, out_en1;
  logic [31:0] out_data1;
  logic [7:0]  out_check1;
  logic [15:0] words_out1;

  logic        in_ready2, out_valid2, out_en2;
  logic [31:0] out_data2;
  logic [7:0]  out_check2;
  logic [3:0]  words_out2;

  int tests_run = 0;
  int fails     = 0;
  logic [71:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  sec32_check_encoder #(.INJ_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_inj(in_inj), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_check(out_check0), .out_en(out_en0), .words_out(words_out0)
  );

  sec32_check_encoder #(.INJ_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_inj(in_inj), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_check(out_check1), .out_en(out_en1), .words_out(words_out1)
  );

  sec32_check_encoder #(.INJ_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_inj(in_inj), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_check(out_check2), .out_en(out_en2), .words_out(words_out2)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c = '0;
    for (int k = 0; k < 8; k++) c[k] = ^(d & TB_MASK[k]);
    return c;
  endfunction

  function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s = ref_chk(d) ^ c;
    logic [31:0] r = d;
    logic [7:0]  col;
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 8; k++) col[k] = TB_MASK[k][j];
      if (s != 8'h00 && col == s) r[j] = ~r[j];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [71:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_data0",  64'(out_data0),  64'(e[31:0]));
          check("sb_check0", 64'(out_check0), 64'(ref_chk(e[31:0])));
          check("sb_data1",  64'(out_data1),  64'(e[31:0] ^ e[71:40]));
          check("sb_check1", 64'(out_check1), 64'(ref_chk(e[31:0]) ^ e[39:32]));
          check("sb_en",     64'(out_en0),    64'd1);
        end
      end
      if (in_valid && in_ready0) exp_q.push_back({in_inj[31:0], in_inj[39:32], in_data});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] vec_d [0:3];
    logic [7:0]  vec_c [0:3];
    logic [31:0] w1, w2, w3, w4;
    int hs;

    vec_d = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
    vec_c = '{8'h00, 8'h51, 8'h8A, 8'h00};
    in_data   = '0;
    in_inj    = '0;
    out_ready = 1'b0;
    do_reset();
    tick();

    // Reset state
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_in_ready",  64'(in_ready0),  64'd1);
    check("rst_out_data",  64'(out_data0),  64'd0);
    check("rst_out_check", 64'(out_check0), 64'd0);
    check("rst_words_out", 64'(words_out0), 64'd0);

    // Parity vectors, back-to-back with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vec_d[i];
      tick();
      check("par_valid", 64'(out_valid0), 64'd1);
      check("par_data",  64'(out_data0),  64'(vec_d[i]));
      check("par_check", 64'(out_check0), 64'(vec_c[i]));
    end
    in_valid = 1'b0;
    tick();
    check("par_drain_valid", 64'(out_valid0), 64'd0);
    check("par_words_out",   64'(words_out0), 64'd4);

    // Back-pressure
    do_reset();
    w1 = 32'h1234_5678; w2 = 32'hDEAD_BEEF; w3 = 32'h0BAD_F00D;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = w1;
    tick();
    check("bp_latency_valid", 64'(out_valid0), 64'd1);
    check("bp_in_ready_1",    64'(in_ready0),  64'd1);
    in_data = w2;
    tick();
    check("bp_in_ready_low", 64'(in_ready0), 64'd0);
    check("bp_hold_w1",      64'(out_data0), 64'(w1));
    in_data = w3;
    tick();
    tick();
    check("bp_still_w1",   64'(out_data0),  64'(w1));
    check("bp_still_chk",  64'(out_check0), 64'(ref_chk(w1)));
    check("bp_still_low",  64'(in_ready0),  64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_w2", 64'(out_data0), 64'(w2));
    check("bp_in_ready_up", 64'(in_ready0), 64'd1);
    tick();
    check("bp_w3", 64'(out_data0), 64'(w3));
    in_valid = 1'b0;
    tick();
    check("bp_drained",   64'(out_valid0), 64'd0);
    check("bp_words_out", 64'(words_out0), 64'd3);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Throughput: 100 random words over 101 edges
    do_reset();
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      in_inj   = {8'($urandom_range(0, 255)), 32'($urandom())};
      if (out_valid0 && out_ready) hs++;
      tick();
    end
    in_valid = 1'b0;
    in_inj   = '0;
    if (out_valid0 && out_ready) hs++;
    tick();
    check("tp_handshakes", 64'(hs), 64'd100);
    check("tp_words_out",  64'(words_out0), 64'd100);
    check("tp_drained",    64'(out_valid0), 64'd0);
    check("tp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Injection
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000001;
    in_inj    = 40'h00_00000001;
    tick();
    in_valid = 1'b0;
    check("inj_data",      64'(out_data1),  64'h0);
    check("inj_check",     64'(out_check1), 64'h51);
    check("inj_corrected", 64'(corr(out_data1, out_check1)), 64'h1);
    check("inj_off_data",  64'(out_data0),  64'h1);
    check("inj_off_check", 64'(out_check0), 64'h51);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00000000;
    in_inj    = 40'h80_00000000;
    tick();
    in_valid = 1'b0;
    in_inj   = '0;
    check("inj_chkbit_data",  64'(out_data1),  64'h0);
    check("inj_chkbit_check", 64'(out_check1), 64'h80);
    check("inj_chkbit_corr",  64'(corr(out_data1, out_check1)), 64'h0);
    tick();

    // Reset mid-stream with main and skid full
    w4 = 32'hCAFE_0004;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    tick();
    in_data = 32'hAAAA_0002;
    tick();
    check("mid_full", 64'(in_ready0), 64'd0);
    do_reset();
    check("mid_out_valid", 64'(out_valid0), 64'd0);
    check("mid_in_ready",  64'(in_ready0),  64'd1);
    check("mid_words_out", 64'(words_out0), 64'd0);
    check("mid_words_out4", 64'(words_out2), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w4;
    tick();
    in_valid = 1'b0;
    check("mid_first_word", 64'(out_data0), 64'(w4));
    tick();
    check("mid_alone",      64'(out_valid0), 64'd0);
    check("mid_words_one",  64'(words_out0), 64'd1);

    // Counter wrap on the 4-bit instance
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i) * 32'h0101_0101;
      tick();
      if (i == 15) check("wrap_at_15", 64'(words_out2), 64'd15);
      if (i == 16) check("wrap_to_0",  64'(words_out2), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    check("wrap_cnt4",  64'(words_out2), 64'd1);
    check("wrap_cnt16", 64'(words_out0), 64'd17);
    tick();
    check("wrap_hold",  64'(words_out2), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
